// File: rtl/lotto_draw.sv
// Draw controller for the shuffling random-number generator.
// Requests a value from the generator and rejects it if it is out of range
// or already drawn. Repeats until K distinct numbers sit in the result buffer.

module lotto_draw #(
    parameter int N    = 4,
    parameter int K    = 3,
    parameter int SPIN = 8
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_fStart,
    input  logic [N-1:0] i_Max,
    output logic         o_fShuffle,
    output logic         o_fStop,
    input  logic         i_fRdy,
    input  logic [N-1:0] i_Num,
    input  logic [3:0]   i_RdIdx,
    output logic [N-1:0] o_RdNum,
    output logic [3:0]   o_Cnt,
    output logic         o_fBusy,
    output logic         o_fDone,
    output logic         o_fErr
);

    localparam int              SW        = $clog2(SPIN);
    localparam int              MAP       = 1 << N;
    localparam logic [SW-1:0]   SPIN_LAST = SW'(SPIN - 1);
    localparam logic [3:0]      K_CNT     = 4'(K);
    localparam logic [31:0]     K_WIDE    = 32'(K);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPIN,
        ST_STOP,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t         state;
    logic [SW-1:0]  spin_cnt;
    logic           shuffle;
    logic           stop;
    logic           busy;
    logic           done;
    logic           err;

    logic [N-1:0]   max_q;
    logic [N-1:0]   hold;
    logic [MAP-1:0] used_map;
    logic [N-1:0]   results [K];
    logic [3:0]     cnt;

    logic [31:0]    max_wide;
    logic           can_start;
    logic           too_few;
    logic           start_ok;
    logic           start_bad;
    logic           capture;
    logic           in_range;
    logic           is_dup;
    logic           accept;
    logic [3:0]     cnt_next;
    logic           last;

    // A start is only legal when the requested range can hold K distinct values.
    assign max_wide  = 32'(i_Max);
    assign can_start = i_fStart && ((state == ST_IDLE) || (state == ST_DONE));
    assign too_few   = K_WIDE > max_wide;
    assign start_ok  = can_start && !too_few;
    assign start_bad = can_start && too_few;

    // The generator value is captured once ready is seen while stop is requested.
    assign capture   = (state == ST_STOP) && i_fRdy;

    // A captured value is kept only if it is in range and not drawn before.
    assign in_range  = hold < max_q;
    assign is_dup    = used_map[hold];
    assign accept    = (state == ST_CHECK) && in_range && !is_dup;
    assign cnt_next  = cnt + 4'd1;
    assign last      = (cnt_next == K_CNT);

    // Sequencing FSM with registered generator controls and status flags.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state    <= ST_IDLE;
            spin_cnt <= '0;
            shuffle  <= 1'b0;
            stop     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            shuffle <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_bad) begin
                        err <= 1'b1;
                    end else if (start_ok) begin
                        err      <= 1'b0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        shuffle  <= 1'b1;
                        spin_cnt <= '0;
                        state    <= ST_SPIN;
                    end
                end
                ST_SPIN: begin
                    if (spin_cnt == SPIN_LAST) begin
                        spin_cnt <= '0;
                        stop     <= 1'b1;
                        state    <= ST_STOP;
                    end else begin
                        spin_cnt <= spin_cnt + SW'(1);
                    end
                end
                ST_STOP: begin
                    if (i_fRdy) begin
                        stop  <= 1'b0;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (accept && last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        shuffle <= 1'b1;
                        state   <= ST_SPIN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Draw datapath: latched range, holding register, used bitmap and results.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            max_q    <= '0;
            hold     <= '0;
            used_map <= '0;
            cnt      <= '0;
            for (int i = 0; i < K; i++) begin
                results[i] <= '0;
            end
        end else if (start_ok) begin
            max_q    <= i_Max;
            used_map <= '0;
            cnt      <= '0;
            for (int i = 0; i < K; i++) begin
                results[i] <= '0;
            end
        end else if (capture) begin
            hold <= i_Num;
        end else if (accept) begin
            used_map[hold] <= 1'b1;
            cnt            <= cnt_next;
            for (int i = 0; i < K; i++) begin
                if (cnt == 4'(i)) begin
                    results[i] <= hold;
                end
            end
        end
    end

    // Result read port; indices beyond the buffer read as zero.
    always_comb begin
        o_RdNum = '0;
        for (int i = 0; i < K; i++) begin
            if (i_RdIdx == 4'(i)) begin
                o_RdNum = results[i];
            end
        end
    end

    assign o_fShuffle = shuffle;
    assign o_fStop    = stop;
    assign o_Cnt      = cnt;
    assign o_fBusy    = busy;
    assign o_fDone    = done;
    assign o_fErr     = err;

endmodule

// File: tb/tb_lotto_draw.sv
// Self-checking bench for lotto_draw: directed vector table, hand-written
// error/stall/reset sequences and randomized draws against a list-based model.

module tb_lotto_draw;

    localparam int N    = 4;
    localparam int K    = 3;
    localparam int SPIN = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] max_in;
    logic       shuffle;
    logic       stop;
    logic       rdy;
    logic [3:0] num;
    logic [3:0] rd_idx;
    logic [3:0] rd_num;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
    logic       err;

    lotto_draw #(.N(N), .K(K), .SPIN(SPIN)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst_n),
        .i_fStart   (start),
        .i_Max      (max_in),
        .o_fShuffle (shuffle),
        .o_fStop    (stop),
        .i_fRdy     (rdy),
        .i_Num      (num),
        .i_RdIdx    (rd_idx),
        .o_RdNum    (rd_num),
        .o_Cnt      (cnt),
        .o_fBusy    (busy),
        .o_fDone    (done),
        .o_fErr     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int max;
        int nvals;
        int vals [8];
        int exp_buf [3];
        int exp_shuf;
    } vec_t;

    vec_t tbl [4];

    int n_cmp = 0;
    int n_bad = 0;

    int gen_q [$];
    int gen_src [$];
    int gen_stall = 0;
    int wait_cnt = 0;

    int shuf_cnt = 0;
    int cycle = 0;
    int last_shuf = -1;
    int min_gap = 1000000;
    int excl_err = 0;
    int cnt_seq [$];

    int m_buf [$];
    int m_cnt [$];
    int m_used = 0;

    int val;
    int hi;
    int rmax;
    int lim;

    // Monitor: counts shuffle pulses, their spacing, and the count seen at each.
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (shuffle === 1'b1) begin
                shuf_cnt++;
                if (last_shuf >= 0 && (cycle - last_shuf) < min_gap) min_gap = cycle - last_shuf;
                last_shuf = cycle;
                cnt_seq.push_back(int'(cnt));
            end
            if (shuffle === 1'b1 && stop === 1'b1) excl_err++;
        end
    end

    // Behavioural generator: goes not-ready on shuffle, answers stop after a stall.
    initial begin
        forever begin
            @(negedge clk);
            if (shuffle === 1'b1) begin
                rdy = 1'b0;
                wait_cnt = 0;
            end else if (stop === 1'b1 && !rdy) begin
                if (wait_cnt >= gen_stall) begin
                    rdy = 1'b1;
                    if (gen_q.size() > 0) num = 4'(gen_q.pop_front());
                    else num = 4'($urandom_range(15, 0));
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic check_output(input string name, input integer actual, input integer expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic read_entry(input int idx, output int v);
        rd_idx = 4'(idx);
        #1;
        v = int'(rd_num);
    endtask

    // Reference: walk the generator values in order, keep in-range new ones.
    task automatic run_model(input int max);
        m_buf.delete();
        m_cnt.delete();
        m_used = 0;
        m_cnt.push_back(0);
        for (int i = 0; i < gen_src.size() && m_buf.size() < K; i++) begin
            int v;
            bit dup;
            v = gen_src[i];
            dup = 1'b0;
            m_used++;
            foreach (m_buf[j]) if (m_buf[j] == v) dup = 1'b1;
            if (v < max && !dup) m_buf.push_back(v);
            m_cnt.push_back(m_buf.size());
        end
    endtask

    task automatic begin_draw(input int max);
        gen_q = gen_src;
        shuf_cnt = 0;
        last_shuf = -1;
        min_gap = 1000000;
        cnt_seq.delete();
        @(negedge clk);
        max_in = 4'(max);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && done !== 1'b1; i++) @(negedge clk);
        if (done === 1'b1) cnt_seq.push_back(int'(cnt));
        check_output("draw_done", done, 1);
    endtask

    task automatic apply_stimulus(input int max);
        begin_draw(max);
        wait_done();
    endtask

    task automatic verify_draw(input string tag, input int max);
        int v;
        run_model(max);
        for (int i = 0; i < K; i++) begin
            read_entry(i, v);
            check_output($sformatf("%s_buf%0d", tag, i), v, (i < m_buf.size()) ? m_buf[i] : -1);
        end
        read_entry(K, v);
        check_output($sformatf("%s_rd_beyond_k", tag), v, 0);
        read_entry(15, v);
        check_output($sformatf("%s_rd_idx15", tag), v, 0);
        check_output($sformatf("%s_cnt", tag), cnt, K);
        check_output($sformatf("%s_busy", tag), busy, 0);
        check_output($sformatf("%s_shuffles", tag), shuf_cnt, m_used);
        check_output($sformatf("%s_cnt_seq_len", tag), cnt_seq.size(), m_cnt.size());
        for (int i = 0; i < cnt_seq.size() && i < m_cnt.size(); i++)
            check_output($sformatf("%s_cnt_seq%0d", tag, i), cnt_seq[i], m_cnt[i]);
        check_output($sformatf("%s_min_gap_ok", tag), (min_gap >= SPIN + 2) ? 1 : 0, 1);
    endtask

    initial begin
        tbl[0].max = 10; tbl[0].nvals = 3;
        tbl[0].vals = '{7, 2, 9, 0, 0, 0, 0, 0};
        tbl[0].exp_buf = '{7, 2, 9}; tbl[0].exp_shuf = 3;
        tbl[1].max = 10; tbl[1].nvals = 5;
        tbl[1].vals = '{5, 5, 3, 5, 8, 0, 0, 0};
        tbl[1].exp_buf = '{5, 3, 8}; tbl[1].exp_shuf = 5;
        tbl[2].max = 6; tbl[2].nvals = 5;
        tbl[2].vals = '{6, 12, 1, 0, 4, 0, 0, 0};
        tbl[2].exp_buf = '{1, 0, 4}; tbl[2].exp_shuf = 5;
        tbl[3].max = 3; tbl[3].nvals = 5;
        tbl[3].vals = '{3, 2, 2, 0, 1, 0, 0, 0};
        tbl[3].exp_buf = '{2, 0, 1}; tbl[3].exp_shuf = 5;

        rst_n = 1'b0;
        start = 1'b0;
        max_in = '0;
        rdy = 1'b0;
        num = '0;
        rd_idx = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_output("rst_shuffle", shuffle, 0);
        check_output("rst_stop", stop, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_err", err, 0);
        check_output("rst_cnt", cnt, 0);
        read_entry(0, val);
        check_output("rst_rdnum", val, 0);
        rst_n = 1'b1;

        // Error path: K greater than Max is refused and nothing starts.
        shuf_cnt = 0;
        @(negedge clk);
        max_in = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("err_flag", err, 1);
        check_output("err_busy", busy, 0);
        check_output("err_done", done, 0);
        repeat (12) @(negedge clk);
        check_output("err_no_shuffle", shuf_cnt, 0);
        gen_src = '{4, 1, 0};
        begin_draw(5);
        check_output("err_cleared", err, 0);
        check_output("err_then_busy", busy, 1);
        wait_done();
        verify_draw("after_err", 5);

        $display("[TB] directed vector table");
        for (int t = 0; t < 4; t++) begin
            gen_src.delete();
            for (int j = 0; j < tbl[t].nvals; j++) gen_src.push_back(tbl[t].vals[j]);
            gen_stall = t % 2;
            apply_stimulus(tbl[t].max);
            verify_draw($sformatf("vec%0d", t), tbl[t].max);
            for (int i = 0; i < K; i++) begin
                read_entry(i, val);
                check_output($sformatf("vec%0d_exp%0d", t, i), val, tbl[t].exp_buf[i]);
            end
            check_output($sformatf("vec%0d_exp_shuf", t), shuf_cnt, tbl[t].exp_shuf);
        end

        // Error from DONE keeps the finished draw intact.
        @(negedge clk);
        max_in = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("done_err_flag", err, 1);
        check_output("done_err_done", done, 1);
        check_output("done_err_cnt", cnt, 3);
        read_entry(0, val);
        check_output("done_err_buf0", val, 2);

        $display("[TB] stall with busy start");
        gen_stall = 1000;
        gen_src = '{4, 11, 2};
        begin_draw(12);
        check_output("stall_err_cleared", err, 0);
        for (int i = 0; i < 500 && stop !== 1'b1; i++) @(negedge clk);
        check_output("stall_stop_seen", stop, 1);
        hi = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (stop === 1'b1) hi++;
            if (c == 20) begin
                max_in = 4'd2;
                start = 1'b1;
            end
            if (c == 21) start = 1'b0;
        end
        check_output("stall_stop_held", hi, 50);
        check_output("stall_busy_start_err", err, 0);
        check_output("stall_still_busy", busy, 1);
        gen_stall = 0;
        wait_done();
        verify_draw("stall", 12);

        $display("[TB] reset mid-draw");
        gen_src = '{7, 2, 9};
        begin_draw(10);
        for (int i = 0; i < 500 && cnt !== 4'd2; i++) @(negedge clk);
        check_output("mid_cnt_two", cnt, 2);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_shuffle", shuffle, 0);
        check_output("mid_rst_stop", stop, 0);
        check_output("mid_rst_busy", busy, 0);
        check_output("mid_rst_done", done, 0);
        check_output("mid_rst_err", err, 0);
        check_output("mid_rst_cnt", cnt, 0);
        read_entry(0, val);
        check_output("mid_rst_rdnum0", val, 0);
        @(negedge clk);
        rst_n = 1'b1;
        gen_src = '{1, 3, 5};
        apply_stimulus(10);
        verify_draw("post_rst", 10);

        $display("[TB] randomized draws");
        for (int r = 0; r < 6; r++) begin
            rmax = $urandom_range(15, 3);
            lim = (rmax + 2 > 15) ? 15 : rmax + 2;
            gen_stall = $urandom_range(3, 0);
            gen_src.delete();
            for (int j = 0; j < 20; j++) gen_src.push_back($urandom_range(lim, 0));
            for (int j = 0; j < rmax; j++) gen_src.push_back(j);
            apply_stimulus(rmax);
            verify_draw($sformatf("rnd%0d", r), rmax);
        end

        check_output("shuffle_stop_excl", excl_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
